imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Front end of stage1if: owns the fetch PC and drives the instruction-memory request/ack port.
//  Buffers returned words with their PC in a 2-entry queue and presents them as
//  pc_in / instr_mem_data / enable to stage1if.
//  Handles downstream stall and branch redirect, including squashing an in-flight fetch.
// PARAMETERS
//  ADDR_W    12      fetch address / PC width (word addressed)
//  DATA_W    12      instruction word width
//  RESET_PC  12'h000 first fetch address after reset
//  Q_DEPTH   2       fetch queue entries (power of two, >=2)
// PORTS
//  clk             in   1       single clock, all state on rising edge
//  rst             in   1       asynchronous reset, active-low (0 = reset)
//  stall           in   1       downstream hold; queue head must not be popped
//  redirect_valid  in   1       branch/jump taken this cycle
//  redirect_pc     in   ADDR_W  new fetch target
//  imem_req        out  1       fetch request valid
//  imem_addr       out  ADDR_W  fetch address, stable while imem_req=1
//  imem_ack        in   1       memory returns imem_rdata this cycle
//  imem_rdata      in   DATA_W  instruction word, valid with imem_ack
//  pc_out          out  ADDR_W  PC of queue head, to stage1if pc_in
//  instr_out       out  DATA_W  queue head word, to stage1if instr_mem_data
//  enable_out      out  1       queue head valid, to stage1if enable
// BEHAVIOUR
//  Reset (rst=0, async):
//   - imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, queue empty.
//   - pc_out=0, instr_out=0, enable_out=0, FSM=IDLE.
//   - Reset mid-request abandons the request; a late imem_ack after release is ignored (FSM IDLE).
//  FSM states: IDLE (no request outstanding), REQ (outstanding, live), SQUASH (outstanding, response to be dropped).
//   - IDLE->REQ when count + 0 < Q_DEPTH (space for the response); imem_req rises the same cycle.
//   - REQ: imem_req=1 and imem_addr held until imem_ack; ack may arrive the cycle req first rises (0 extra latency).
//   - REQ: ack pushes {fetch_pc, imem_rdata}; fetch_pc <= fetch_pc+1.
//   - REQ: back-to-back issue stays in REQ if space remains after the push/pop this cycle, else goes to IDLE.
//   - REQ, redirect_valid && !imem_ack -> SQUASH: request stays asserted (never withdrawn), fetch_pc <= redirect_pc.
//   - SQUASH: on imem_ack, word is discarded (no push); go to REQ with imem_addr=fetch_pc.
//  Redirect:
//   - Flushes the queue in the same cycle, so enable_out=0 next cycle.
//   - Takes priority over a simultaneous push, pop or ack; the acked word is dropped.
//   - In IDLE or on ack cycles: fetch_pc <= redirect_pc, next request uses redirect_pc.
//  Queue:
//   - pop when enable_out && !stall; outputs are combinational from the head entry.
//   - Outputs held stable while stall=1; 0 with enable_out=0 when empty.
//   - Simultaneous push+pop when full is legal (count unchanged).
//   - A push into a full queue is impossible by the issue rule; assert this in sim.
//  Arithmetic: fetch_pc+1 is modulo 2^ADDR_W (12'hFFF -> 12'h000), no flag.
//  Throughput: 1 word/cycle with zero-latency memory and no stall.
//  Fetch latency: pc issue -> enable_out is 1 cycle after ack.
// STRUCTURE
//  - diad_pkg: ADDR_W/DATA_W defaults, RESET_PC, NOP word (12'h000), FSM state encoding (IDLE/REQ/SQUASH).
//  - Sub-module fetch_queue (Q_DEPTH x {pc,instr}): push, pop, flush, count; async active-low clear.
//  - Top holds FSM, fetch_pc, issue rule, redirect/squash logic.
// TESTING
//  - Reset: hold rst=0 5 cycles, release; imem_req=1 with addr 000 the next cycle, enable_out=0 until first ack.
//  - Zero-latency memory (ack=req), rdata=addr^12'hA5A, stall=0:
//    - pc_out/instr_out stream 000/A5A, 001/A5B, ...
//    - enable_out continuously 1 after the first word.
//  - stall=1 for 6 cycles:
//    - queue fills to 2, imem_req drops to 0.
//    - pc_out/instr_out frozen.
//    - release: words resume in order, none lost or duplicated.
//  - 3-cycle ack latency with redirect_valid pulse (redirect_pc=12'h120) in the 2nd wait cycle:
//    - pending word dropped, queue flushed.
//    - next imem_addr=120, next enable_out word has pc_out=120.
//  - Wrap: RESET_PC=12'hFFE with free-running fetch -> pc_out sequence FFE, FFF, 000, 001.
//  - rst pulse while imem_req=1 and queue holds 2:
//    - all outputs zero immediately (async).
//    - a late ack during reset produces no enable_out.
//    - restart at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared defaults and FSM encoding for the stage1if fetch front end.
package imem_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF   = 12;
    localparam int unsigned DATA_W_DEF   = 12;
    localparam int unsigned Q_DEPTH_DEF  = 2;
    localparam logic [11:0] RESET_PC_DEF = 12'h000;
    localparam logic [11:0] NOP_WORD     = 12'h000;

    // SQUASH: a request is still outstanding but its response belongs to a dead path.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_SQUASH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// Small FIFO of fetched {pc, instr} pairs; head is presented combinationally.
module fetch_queue
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned Q_DEPTH = Q_DEPTH_DEF,
    localparam int unsigned PTR_W  = $clog2(Q_DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_pc,
    input  logic [DATA_W-1:0] i_push_instr,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_instr,
    output logic [CNT_W-1:0]  o_count
);

    logic [ADDR_W-1:0] r_pc    [Q_DEPTH];
    logic [DATA_W-1:0] r_instr [Q_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop;

    assign o_valid = (r_count != '0);
    assign w_pop   = i_pop && o_valid;
    assign o_count = r_count;
    assign o_pc    = o_valid ? r_pc[r_rd_ptr]    : '0;
    assign o_instr = o_valid ? r_instr[r_rd_ptr] : DATA_W'(NOP_WORD);

    // Flush wins over a simultaneous push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_pc[r_wr_ptr]    <= i_push_pc;
            r_instr[r_wr_ptr] <= i_push_instr;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && (r_count == CNT_W'(Q_DEPTH)) && !w_pop));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch PC owner: drives the imem request/ack port, queues returned words for stage1if,
// and handles stall plus branch redirect including squash of an in-flight fetch.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned       Q_DEPTH  = Q_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] instr_out,
    output logic              enable_out
);

    localparam int unsigned CNT_W = $clog2(Q_DEPTH) + 1;

    fetch_state_t      r_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_fetch_pc;

    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_space;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] w_next_pc;

    assign w_pop  = w_valid && !stall;
    assign w_push = (r_state == ST_REQ) && imem_ack && !redirect_valid;

    // Issue only if the queue can still absorb a response after this cycle's push/pop/flush.
    always_comb begin
        w_cnt_next = '0;
        if (!redirect_valid)
            w_cnt_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
    assign w_space = (w_cnt_next < CNT_W'(Q_DEPTH));

    always_comb begin
        w_next_pc = r_fetch_pc;
        if (redirect_valid)
            w_next_pc = redirect_pc;
        else if (w_push)
            w_next_pc = r_fetch_pc + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_fetch_pc <= w_next_pc;
            case (r_state)
                ST_IDLE: begin
                    if (w_space) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= w_next_pc;
                    end
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        if (w_space) begin
                            r_addr <= w_next_pc;
                        end else begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                        end
                    end else if (redirect_valid) begin
                        r_state <= ST_SQUASH;
                    end
                end
                ST_SQUASH: begin
                    // Queue was flushed on entry and nothing is pushed here, so space is guaranteed.
                    if (imem_ack) begin
                        r_state <= ST_REQ;
                        r_addr  <= w_next_pc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .Q_DEPTH (Q_DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst),
        .i_push       (w_push),
        .i_push_pc    (r_fetch_pc),
        .i_push_instr (imem_rdata),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .o_valid      (w_valid),
        .o_pc         (pc_out),
        .o_instr      (instr_out),
        .o_count      (w_count)
    );

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign enable_out = w_valid;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: vector table, directed redirect/reset sequences, random run
// checked against an in-order stream model of the fetched program.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [11:0] imem_rdata;
    logic [11:0] pc_out;
    logic [11:0] instr_out;
    logic        enable_out;

    logic        w_req;
    logic [11:0] w_addr;
    logic [11:0] w_pc;
    logic [11:0] w_instr;
    logic        w_en;

    int unsigned total;
    int unsigned bad;

    bit          mem_auto;
    bit          mem_rand;
    int unsigned mem_lat;
    int unsigned wait_cnt;

    bit          mon_on;
    logic [11:0] exp_pc;
    int unsigned n_pops;
    logic        p_req, p_ack, p_en, p_stall, p_redir;
    logic [11:0] p_addr, p_pc;

    typedef struct {
        logic        stall;
        logic        req;
        logic [11:0] addr;
        logic        en;
        logic [11:0] pc;
    } vec_t;

    vec_t        tbl [16];
    logic [11:0] wrap_exp [4];

    imem_fetch_ctrl u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .enable_out     (enable_out)
    );

    // Free-running zero-latency fetch from a start address just below the wrap point.
    imem_fetch_ctrl #(
        .RESET_PC (12'hFFE)
    ) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (12'h000),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (w_req),
        .imem_rdata     (w_addr ^ 12'hA5A),
        .pc_out         (w_pc),
        .instr_out      (w_instr),
        .enable_out     (w_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory: acknowledges after mem_lat wait cycles, data word = address ^ A5A.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        wait_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                if (!rst || !imem_req) begin
                    imem_ack = 1'b0;
                    wait_cnt = 0;
                end else if (wait_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr ^ 12'hA5A;
                    wait_cnt   = 0;
                    if (mem_rand) mem_lat = $urandom_range(0, 3);
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end
        end
    end

    // Stream model: words leave in program order, each carrying its own address's data,
    // a redirect restarts the stream at its target and empties the output next cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (p_req && !p_ack) begin
                    chk("req_held", 32'(imem_req), 32'd1);
                    chk("addr_held", 32'(imem_addr), 32'(p_addr));
                end
                if (p_redir)
                    chk("flush_en", 32'(enable_out), 32'd0);
                else if (p_en && p_stall) begin
                    chk("stall_en", 32'(enable_out), 32'd1);
                    chk("stall_pc", 32'(pc_out), 32'(p_pc));
                end
                if (enable_out) begin
                    chk("rnd_pc", 32'(pc_out), 32'(exp_pc));
                    chk("rnd_instr", 32'(instr_out), 32'(pc_out ^ 12'hA5A));
                end
                if (redirect_valid)
                    exp_pc = redirect_pc;
                else if (enable_out && !stall) begin
                    exp_pc = pc_out + 12'd1;
                    n_pops++;
                end
                p_req   = imem_req;
                p_ack   = imem_ack;
                p_addr  = imem_addr;
                p_en    = enable_out;
                p_pc    = pc_out;
                p_stall = stall;
                p_redir = redirect_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h000);
        chk("rst_en", 32'(enable_out), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_instr", 32'(instr_out), 32'd0);
    endtask

    initial begin
        total = 0; bad = 0; n_pops = 0;
        mon_on = 1'b0; exp_pc = '0;
        p_req = 0; p_ack = 0; p_en = 0; p_stall = 0; p_redir = 0; p_addr = '0; p_pc = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_auto = 1'b1; mem_rand = 1'b0; mem_lat = 0;

        // {stall, req, addr, en, pc}: stream, 6-cycle stall, resume
        tbl[0]  = '{1'b0, 1'b1, 12'h000, 1'b0, 12'h000};
        tbl[1]  = '{1'b0, 1'b1, 12'h001, 1'b1, 12'h000};
        tbl[2]  = '{1'b0, 1'b1, 12'h002, 1'b1, 12'h001};
        tbl[3]  = '{1'b0, 1'b1, 12'h003, 1'b1, 12'h002};
        tbl[4]  = '{1'b0, 1'b1, 12'h004, 1'b1, 12'h003};
        tbl[5]  = '{1'b0, 1'b1, 12'h005, 1'b1, 12'h004};
        tbl[6]  = '{1'b1, 1'b1, 12'h006, 1'b1, 12'h005};
        tbl[7]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h005};
        tbl[8]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h005};
        tbl[9]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h005};
        tbl[10] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h005};
        tbl[11] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h005};
        tbl[12] = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h005};
        tbl[13] = '{1'b0, 1'b1, 12'h007, 1'b1, 12'h006};
        tbl[14] = '{1'b0, 1'b1, 12'h008, 1'b1, 12'h007};
        tbl[15] = '{1'b0, 1'b1, 12'h009, 1'b1, 12'h008};
        wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF;
        wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h001;

        do_reset();
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1 stall = tbl[k].stall;
            @(negedge clk);
            chk($sformatf("tbl%0d_req", k), 32'(imem_req), 32'(tbl[k].req));
            if (tbl[k].req) chk($sformatf("tbl%0d_addr", k), 32'(imem_addr), 32'(tbl[k].addr));
            chk($sformatf("tbl%0d_en", k), 32'(enable_out), 32'(tbl[k].en));
            if (tbl[k].en) begin
                chk($sformatf("tbl%0d_pc", k), 32'(pc_out), 32'(tbl[k].pc));
                chk($sformatf("tbl%0d_instr", k), 32'(instr_out), 32'(tbl[k].pc ^ 12'hA5A));
            end
            if (k >= 1 && k <= 4) begin
                chk($sformatf("wrap%0d_en", k), 32'(w_en), 32'd1);
                chk($sformatf("wrap%0d_pc", k), 32'(w_pc), 32'(wrap_exp[k-1]));
            end
        end

        // 3-wait-cycle memory, redirect to 120 in the 2nd wait cycle of the fetch of 001
        stall   = 1'b1;
        mem_lat = 3;
        do_reset();
        for (int s = 1; s <= 13; s++) begin
            @(posedge clk);
            #1;
            redirect_valid = (s == 6);
            redirect_pc    = 12'h120;
            @(negedge clk);
            case (s)
                5: begin
                    chk("lat_first_en", 32'(enable_out), 32'd1);
                    chk("lat_first_pc", 32'(pc_out), 32'h000);
                end
                6: begin
                    chk("redir_cyc_en", 32'(enable_out), 32'd1);
                    chk("redir_cyc_addr", 32'(imem_addr), 32'h001);
                end
                7: begin
                    chk("sq_en", 32'(enable_out), 32'd0);
                    chk("sq_req", 32'(imem_req), 32'd1);
                    chk("sq_addr", 32'(imem_addr), 32'h001);
                end
                8: chk("sq_ack_en", 32'(enable_out), 32'd0);
                9: begin
                    chk("tgt_req", 32'(imem_req), 32'd1);
                    chk("tgt_addr", 32'(imem_addr), 32'h120);
                    chk("tgt_en", 32'(enable_out), 32'd0);
                end
                13: begin
                    chk("tgt_word_en", 32'(enable_out), 32'd1);
                    chk("tgt_word_pc", 32'(pc_out), 32'h120);
                    chk("tgt_word_instr", 32'(instr_out), 32'(12'h120 ^ 12'hA5A));
                end
                default: ;
            endcase
        end

        // Async reset mid-request with a word queued; a late ack must be ignored
        mem_auto = 1'b0;
        imem_ack = 1'b0;
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        chk("pre_rst_en", 32'(enable_out), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_en", 32'(enable_out), 32'd0);
        chk("arst_pc", 32'(pc_out), 32'd0);
        chk("arst_instr", 32'(instr_out), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'h000);
        imem_ack   = 1'b1;
        imem_rdata = 12'h777;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("late_ack_en0", 32'(enable_out), 32'd0);
        chk("late_ack_req0", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("late_ack_en1", 32'(enable_out), 32'd0);
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", 32'(imem_addr), 32'h000);
        imem_ack = 1'b0;
        stall    = 1'b0;
        mem_lat  = 0;
        mem_auto = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("restart_wait_en", 32'(enable_out), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("restart_en", 32'(enable_out), 32'd1);
        chk("restart_pc", 32'(pc_out), 32'h000);
        chk("restart_instr", 32'(instr_out), 32'hA5A);

        // Random stall/redirect/latency against the stream model
        mem_rand = 1'b1;
        stall    = 1'b0;
        do_reset();
        exp_pc = 12'h000;
        p_req = 0; p_ack = 0; p_en = 0; p_stall = 0; p_redir = 0;
        mon_on = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            stall          = ($urandom_range(0, 99) < 30);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc    = 12'($urandom);
        end
        @(negedge clk);
        #1 mon_on = 1'b0;
        chk("rnd_progress", 32'(n_pops >= 300), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
